// File: rtl/hex_display_scan.sv
// hex_display_scan: double-buffered, time-multiplexed scanner for a common-anode hex display.
// Define HEX_DISPLAY_LZB_EN to compile in leading-zero blanking.
module hex_display_scan #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [4*DIGITS-1:0]   valueIn,
  input  logic                  loadIn,
  output logic [3:0]            nOut,
  output logic [DIGITS-1:0]     anOut,
  output logic                  busyOut
);
  localparam int CW = $clog2(PRESCALE);
  localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [CW-1:0]       cnt, cnt_n;
  logic [DW-1:0]       digit, digit_n;
  logic [4*DIGITS-1:0] shadow, shadow_n, disp, disp_n;
  logic                pending, pending_n, last, wrap, blank;
  always_comb begin
    last      = cnt == CW'(PRESCALE - 1);
    wrap      = last && digit == DW'(DIGITS - 1);
    cnt_n     = last ? '0 : cnt + 1'b1;
    digit_n   = !last ? digit : wrap ? '0 : digit + 1'b1;
    disp_n    = (wrap && loadIn) ? valueIn : (wrap && pending) ? shadow : disp;
    shadow_n  = (loadIn && !wrap) ? valueIn : shadow;
    pending_n = !wrap && (loadIn || pending);
`ifdef HEX_DISPLAY_LZB_EN
    blank     = digit_n != '0 && (disp_n >> {digit_n, 2'b00}) == '0;
`else
    blank     = 1'b0;
`endif
  end
  // Outputs are computed from next state so they stay registered yet aligned with cnt/digit.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt     <= '0;
      digit   <= '0;
      shadow  <= '0;
      disp    <= '0;
      pending <= 1'b0;
      nOut    <= 4'h0;
      anOut   <= '1;
      busyOut <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      digit   <= digit_n;
      shadow  <= shadow_n;
      disp    <= disp_n;
      pending <= pending_n;
      nOut    <= disp_n[{digit_n, 2'b00} +: 4];
      anOut   <= (cnt_n == '0 || blank) ? '1 : ~(DIGITS'(1) << digit_n);
      busyOut <= pending_n;
    end
  end
endmodule
